teclado_atm: RTL and testbench
==============================

# teclado_atm

Keypad front-end for the ATM controller, directly upstream of it. Filters raw key presses from the cabinet keypad into one event per press, then forwards PIN digits as a single-cycle `DIGITO`/`DIGITO_STB` pair, or assembles a decimal amount into `MONTO` with a single-cycle `MONTO_STB`. All controller-facing outputs are registered.

## Interface
- `DEBOUNCE_CICLOS`, default 4: consecutive stable synchronized samples required to accept a press or a release (≥1).
- `MAX_DIGITOS`, default 9: maximum amount digits; 9 keeps the value ≤ 999 999 999, below 2^32.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `TECLA_VALIDA`  input  1  raw key-down level from the keypad, asynchronous.
- `TECLA`  input  4  raw key code: 0–9 digits, 4'hA BORRAR, 4'hB ENTER, 4'hC–4'hF unused.
- `MODO_MONTO`  input  1  0 = PIN entry, 1 = amount entry; driven synchronously by the controller.
- `DIGITO`  output  4  accepted PIN digit.
- `DIGITO_STB`  output  1  one-cycle pulse while `DIGITO` is valid.
- `MONTO`  output  32  confirmed amount, binary.
- `MONTO_STB`  output  1  one-cycle pulse when `MONTO` is updated.
- `DESBORDE`  output  1  one-cycle pulse when an amount digit is rejected at `MAX_DIGITOS`.

## Operation
- Synchronizer: 2-flop synchronizers on `TECLA_VALIDA` and on each bit of `TECLA`. Only synchronized values (`v_s`, `t_s`) are used downstream.
- Debounce FSM states:
  - REPOSO → FILTRO_PRES when `v_s`=1. Capture `t_s`; counter=1.
  - FILTRO_PRES:
    - `v_s`=0 → REPOSO.
    - `t_s` differs from the captured code → recapture the code; counter=1.
    - Otherwise counter+1. When counter reaches `DEBOUNCE_CICLOS`, emit an internal press event with the captured code and go to PRESIONADA.
  - PRESIONADA → FILTRO_LIB when `v_s`=0; counter=1.
  - FILTRO_LIB:
    - `v_s`=1 → PRESIONADA. No new event.
    - `v_s`=0 → counter+1. When counter reaches `DEBOUNCE_CICLOS`, go to REPOSO.
- A key held indefinitely produces exactly one event. A new press is accepted only after the release has been filtered.
- Event handling, `MODO_MONTO`=0:
  - Code 0–9 → `DIGITO`=code and `DIGITO_STB`=1 for one cycle.
  - Other codes are ignored.
- Event handling, `MODO_MONTO`=1:
  - Digit, count < `MAX_DIGITOS` → acc = acc*10 + code; count+1.
  - Digit, count = `MAX_DIGITOS` → acc unchanged; `DESBORDE` pulse.
  - BORRAR → acc=0; count=0.
  - ENTER, count>0 → `MONTO`=acc, `MONTO_STB` pulse, acc=0, count=0.
  - ENTER, count=0 → ignored.
  - 4'hC–4'hF → ignored.
- Arithmetic: acc is 32 bits. acc*10 is computed as (acc<<3)+(acc<<1). No overflow is possible within `MAX_DIGITOS`=9. The count register is wide enough for `MAX_DIGITOS`.
- `MODO_MONTO` edge (either direction): acc and count clear on the following clock edge. An event occurring in that same cycle is processed under the new mode after clearing.
- `MONTO` holds its value until the next valid ENTER or reset.
- `DIGITO` holds the last accepted digit between strobes.
- Reset value of every output and register is 0 (`DIGITO`, `DIGITO_STB`, `MONTO`, `MONTO_STB`, `DESBORDE`, acc, count, FSM=REPOSO, synchronizers, counter).
- Reset asserted mid-press: FSM returns to REPOSO. If the key is still down after reset deassertion, it is filtered as a new press.

## Timing
- Define edge 0 as the first clock edge that samples `TECLA_VALIDA`=1 into the first synchronizer flop.
- With `TECLA_VALIDA` and `TECLA` stable, the strobe (`DIGITO_STB`, or the acc update) is visible after edge `DEBOUNCE_CICLOS`+2.
- `MONTO_STB` follows the same latency for the ENTER press.
- All strobes are exactly one cycle wide. At most one strobe output is asserted in any cycle.
- Minimum press-to-press spacing: release held low for `DEBOUNCE_CICLOS`+2 cycles.
- No backpressure: the controller must accept every strobe in the cycle it is asserted.

## Test plan
- `DEBOUNCE_CICLOS`=4, PIN mode, press 3, 7, 6, 1, each held 10 cycles with 10 cycles released → four `DIGITO_STB` pulses carrying 3, 7, 6, 1. Each pulse appears 6 edges after its press.
- Bounce: `TECLA_VALIDA` toggles 1,0,1,0 every cycle, then is held high with key 5 → exactly one strobe with `DIGITO`=5. Release bounce of high-low-high produces no second strobe.
- Amount mode: keys 2,0,0,0 then ENTER → `MONTO`=2000 and one `MONTO_STB`. A second ENTER → no strobe; `MONTO` stays 2000.
- Amount mode: keys 9,BORRAR,4,5,ENTER → `MONTO`=45. Ten 9s then ENTER → one `DESBORDE` on the tenth 9, then `MONTO`=999999999.
- Keys 1,2 in amount mode; `MODO_MONTO` switched to 0 then back to 1; then 7, ENTER → `MONTO`=7.
- `rst` pulsed low while key 8 is held in PRESIONADA with all outputs previously nonzero → all outputs read 0 during reset. After release of reset with the key still held, exactly one `DIGITO_STB` with `DIGITO`=8.

Source files
------------

// File: rtl/teclado_atm.sv
// Keypad front-end: synchronizes and debounces raw key presses, then forwards
// PIN digits one at a time or assembles a decimal amount for the ATM controller.
module teclado_atm #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int MAX_DIGITOS     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TECLA_VALIDA,
  input  logic [3:0]  TECLA,
  input  logic        MODO_MONTO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        DESBORDE
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int DW = $clog2(MAX_DIGITOS + 1);

  localparam logic [3:0] BORRAR = 4'hA;
  localparam logic [3:0] ENTER  = 4'hB;

  typedef enum logic [1:0] {REPOSO, FILTRO_PRES, PRESIONADA, FILTRO_LIB} estado_t;

  logic [1:0]    v_sync;
  logic [3:0]    t_sync;
  logic [3:0]    t_s;
  logic          v_s;
  estado_t       estado;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    code;
  logic          ev;

  logic          modo_q;
  logic [31:0]   acc;
  logic [DW-1:0] dcnt;
  logic [31:0]   acc_base;
  logic [DW-1:0] dcnt_base;
  logic [31:0]   acc_x10;

  assign v_s     = v_sync[1];
  assign cnt_inc = cnt + CW'(1);

  // NOTE: every register, synchronizers included, resets asynchronously so a
  // reset mid-press restarts filtering cleanly from REPOSO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_sync <= '0;
      t_sync <= '0;
      t_s    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so each flop
      // samples the pre-edge value of the previous stage.
      v_sync <= {v_sync[0], TECLA_VALIDA};
      t_sync <= TECLA;
      t_s    <= t_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= REPOSO;
      cnt    <= '0;
      code   <= '0;
      ev     <= 1'b0;
    end else begin
      ev <= 1'b0;
      case (estado)
        REPOSO: if (v_s) begin
          code <= t_s;
          cnt  <= CW'(1);
          if (DEBOUNCE_CICLOS <= 1) begin
            ev     <= 1'b1;
            estado <= PRESIONADA;
          end else begin
            estado <= FILTRO_PRES;
          end
        end
        FILTRO_PRES: begin
          if (!v_s) begin
            estado <= REPOSO;
          end else if (t_s != code) begin
            code <= t_s;
            cnt  <= CW'(1);
          end else if (cnt_inc >= CW'(DEBOUNCE_CICLOS)) begin
            ev     <= 1'b1;
            estado <= PRESIONADA;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESIONADA: if (!v_s) begin
          cnt    <= CW'(1);
          estado <= FILTRO_LIB;
        end
        FILTRO_LIB: begin
          if (v_s) begin
            estado <= PRESIONADA;
          end else if (cnt_inc >= CW'(DEBOUNCE_CICLOS)) begin
            estado <= REPOSO;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

  // A mode change discards any partial amount before the same-cycle event is applied.
  always_comb begin
    acc_base  = (MODO_MONTO != modo_q) ? '0 : acc;
    dcnt_base = (MODO_MONTO != modo_q) ? '0 : dcnt;
    acc_x10   = (acc_base << 3) + (acc_base << 1) + {28'd0, code};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modo_q     <= 1'b0;
      acc        <= '0;
      dcnt       <= '0;
      DIGITO     <= '0;
      DIGITO_STB <= 1'b0;
      MONTO      <= '0;
      MONTO_STB  <= 1'b0;
      DESBORDE   <= 1'b0;
    end else begin
      modo_q     <= MODO_MONTO;
      acc        <= acc_base;
      dcnt       <= dcnt_base;
      DIGITO_STB <= 1'b0;
      MONTO_STB  <= 1'b0;
      DESBORDE   <= 1'b0;
      if (ev) begin
        if (!MODO_MONTO) begin
          if (code <= 4'd9) begin
            DIGITO     <= code;
            DIGITO_STB <= 1'b1;
          end
        end else if (code <= 4'd9) begin
          if (dcnt_base < DW'(MAX_DIGITOS)) begin
            acc  <= acc_x10;
            dcnt <= dcnt_base + DW'(1);
          end else begin
            DESBORDE <= 1'b1;
          end
        end else if (code == BORRAR) begin
          acc  <= '0;
          dcnt <= '0;
        end else if (code == ENTER && dcnt_base != '0) begin
          MONTO     <= acc_base;
          MONTO_STB <= 1'b1;
          acc       <= '0;
          dcnt      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_atm.sv
// Scoreboard bench for teclado_atm: stimulus pushes expected strobes, a
// negedge monitor pops and compares them as the DUT presents them.
module tb_teclado_atm;

  localparam int D = 4;
  localparam int LAT = D + 2;

  localparam int K_DIG = 0;
  localparam int K_MON = 1;
  localparam int K_DES = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          t0;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        TECLA_VALIDA = 1'b0;
  logic [3:0]  TECLA = 4'd0;
  logic        MODO_MONTO = 1'b0;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        DESBORDE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];

  logic [31:0] m_acc = '0;
  int          m_cnt = 0;
  logic        m_mode = 1'b0;

  teclado_atm #(.DEBOUNCE_CICLOS(D), .MAX_DIGITOS(9)) dut (
    .clk(clk), .rst(rst), .TECLA_VALIDA(TECLA_VALIDA), .TECLA(TECLA),
    .MODO_MONTO(MODO_MONTO), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
    .MONTO(MONTO), .MONTO_STB(MONTO_STB), .DESBORDE(DESBORDE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val, input int t0, input bit chk_lat);
    exp_t e;
    e.kind = kind; e.val = val; e.t0 = t0; e.chk_lat = chk_lat;
    sb.push_back(e);
  endtask

  // Reference behaviour of one accepted key press.
  task automatic model_key(input logic [3:0] key, input int t0, input bit chk_lat);
    if (!m_mode) begin
      if (key <= 4'd9) push(K_DIG, {28'd0, key}, t0, chk_lat);
    end else if (key <= 4'd9) begin
      if (m_cnt < 9) begin
        m_acc = m_acc * 10 + {28'd0, key};
        m_cnt++;
      end else begin
        push(K_DES, 32'd0, t0, chk_lat);
      end
    end else if (key == 4'hA) begin
      m_acc = '0; m_cnt = 0;
    end else if (key == 4'hB && m_cnt > 0) begin
      push(K_MON, m_acc, t0, chk_lat);
      m_acc = '0; m_cnt = 0;
    end
  endtask

  task automatic press(input logic [3:0] key);
    @(negedge clk);
    TECLA = key;
    TECLA_VALIDA = 1'b1;
    model_key(key, cyc, 1'b1);
    repeat (10) @(negedge clk);
    TECLA_VALIDA = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    MODO_MONTO = m;
    if (m != m_mode) begin
      m_acc = '0; m_cnt = 0; m_mode = m;
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int n;
    int kind;
    logic [31:0] v;
    exp_t e;
    n = int'(DIGITO_STB) + int'(MONTO_STB) + int'(DESBORDE);
    if (n > 1) check("one_strobe", n, 1);
    if (n >= 1) begin
      kind = DIGITO_STB ? K_DIG : (MONTO_STB ? K_MON : K_DES);
      v = (kind == K_DIG) ? {28'd0, DIGITO} : ((kind == K_MON) ? MONTO : 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got kind %0d value %0d expected none", kind, v);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_value", v, e.val);
        if (e.chk_lat) check("strobe_latency", cyc - e.t0 - 1, LAT);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digito", {28'd0, DIGITO}, 0);
    check("rst_digito_stb", DIGITO_STB, 0);
    check("rst_monto", MONTO, 0);
    check("rst_monto_stb", MONTO_STB, 0);
    check("rst_desborde", DESBORDE, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // PIN digits
    press(4'd3); press(4'd7); press(4'd6); press(4'd1);
    repeat (5) @(negedge clk);
    check("digito_hold", {28'd0, DIGITO}, 1);

    // Press bounce then release bounce: one strobe only
    @(negedge clk); TECLA = 4'd5; TECLA_VALIDA = 1'b1;
    @(negedge clk); TECLA_VALIDA = 1'b0;
    @(negedge clk); TECLA_VALIDA = 1'b1;
    @(negedge clk); TECLA_VALIDA = 1'b0;
    @(negedge clk); TECLA_VALIDA = 1'b1;
    push(K_DIG, 32'd5, 0, 1'b0);
    repeat (12) @(negedge clk);
    TECLA_VALIDA = 1'b0;
    @(negedge clk); TECLA_VALIDA = 1'b1;
    @(negedge clk); TECLA_VALIDA = 1'b0;
    repeat (12) @(negedge clk);
    check("digito_bounce", {28'd0, DIGITO}, 5);

    // Amount entry
    set_mode(1'b1);
    press(4'd2); press(4'd0); press(4'd0); press(4'd0); press(4'hB);
    check("monto_2000", MONTO, 32'd2000);
    press(4'hB);
    check("monto_hold_2000", MONTO, 32'd2000);

    press(4'd9); press(4'hA); press(4'd4); press(4'd5); press(4'hB);
    check("monto_45", MONTO, 32'd45);

    for (int i = 0; i < 10; i++) press(4'd9);
    press(4'hB);
    check("monto_max", MONTO, 32'd999999999);

    press(4'd1); press(4'd2);
    set_mode(1'b0);
    set_mode(1'b1);
    press(4'd7); press(4'hB);
    check("monto_7", MONTO, 32'd7);

    // Reset while key 8 is held down
    set_mode(1'b0);
    @(negedge clk); TECLA = 4'd8; TECLA_VALIDA = 1'b1;
    model_key(4'd8, cyc, 1'b1);
    repeat (12) @(negedge clk);
    check("pre_rst_digito", {28'd0, DIGITO}, 8);
    rst = 1'b0;
    #1;
    check("mid_rst_digito", {28'd0, DIGITO}, 0);
    check("mid_rst_monto", MONTO, 0);
    check("mid_rst_digito_stb", DIGITO_STB, 0);
    check("mid_rst_monto_stb", MONTO_STB, 0);
    check("mid_rst_desborde", DESBORDE, 0);
    m_acc = '0; m_cnt = 0; m_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push(K_DIG, 32'd8, 0, 1'b0);
    repeat (20) @(negedge clk);
    TECLA_VALIDA = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
